// File: rtl/implied_sweep_scheduler_pkg.sv
// Shared types and constants for the implied sweep scheduler: FSM states,
// source encoding and the default number of price levels per side.
package implied_pkg;

    localparam int N_LEVELS_DEFAULT = 10;

    localparam logic SRC_U = 1'b0;
    localparam logic SRC_V = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SWEEP,
        DONE
    } state_t;

endpackage

// File: rtl/implied_sweep_scheduler_if.sv
// Handshake bundle between the book-update requesters, the scheduler and the
// implied datapath; the master modport is the scheduler side.
interface implied_sweep_scheduler_if #(
    parameter int LEVEL_W = 4
);

    logic               u_upd_req;
    logic               u_upd_ack;
    logic               v_upd_req;
    logic               v_upd_ack;
    logic               calc_valid;
    logic               calc_ready;
    logic [LEVEL_W-1:0] calc_level;
    logic               calc_src;
    logic               sweep_done;
    logic               busy;

    modport master (
        input  u_upd_req,
        input  v_upd_req,
        input  calc_ready,
        output u_upd_ack,
        output v_upd_ack,
        output calc_valid,
        output calc_level,
        output calc_src,
        output sweep_done,
        output busy
    );

    modport slave (
        output u_upd_req,
        output v_upd_req,
        output calc_ready,
        input  u_upd_ack,
        input  v_upd_ack,
        input  calc_valid,
        input  calc_level,
        input  calc_src,
        input  sweep_done,
        input  busy
    );

endinterface

// File: rtl/implied_sweep_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: on contention the source that was not
// granted last wins; the pointer moves only when a grant is taken.
module rr_arbiter2
    import implied_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_u,
    input  logic req_v,
    input  logic grant_en,
    output logic grant_any,
    output logic grant_src
);

    // Source that wins the next tie; starts at U so the first grant goes to U.
    logic ptr;

    always_comb begin
        grant_any = req_u | req_v;
        grant_src = SRC_U;
        if (req_u && req_v) begin
            grant_src = ptr;
        end else if (req_v) begin
            grant_src = SRC_V;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= SRC_U;
        end else if (grant_en && grant_any) begin
            ptr <= ~grant_src;
        end
    end

endmodule

// File: rtl/implied_sweep_scheduler.sv
// Implied-price sweep scheduler: arbitrates U/V book updates and walks the
// level index 0..N_LEVELS-1 into the datapath. IMPLIED_COALESCE_EN enables coalescing.
module implied_sweep_scheduler
    import implied_pkg::*;
#(
    parameter int N_LEVELS = N_LEVELS_DEFAULT,
    parameter int LEVEL_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    implied_sweep_scheduler_if.master  bus
);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(N_LEVELS - 1);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               src_q, src_d;
    logic               arb_any, arb_src;
    logic               u_ack_c, v_ack_c, valid_c, done_c;

    rr_arbiter2 arb (
        .clk       (clk),
        .reset     (reset),
        .req_u     (bus.u_upd_req),
        .req_v     (bus.v_upd_req),
        .grant_en  (state_q == IDLE),
        .grant_any (arb_any),
        .grant_src (arb_src)
    );

`ifdef IMPLIED_COALESCE_EN
    // Requests seen mid-sweep are acked one cycle later and folded into one re-sweep.
    logic u_ack_q, v_ack_q, pend_q, pend_src_q;
    logic take_u, take_v, pend_eff, pend_src_eff;

    always_comb begin
        take_u       = (state_q == SWEEP || state_q == DONE) && bus.u_upd_req && !u_ack_q;
        take_v       = (state_q == SWEEP || state_q == DONE) && bus.v_upd_req && !v_ack_q;
        pend_eff     = pend_q | take_u | take_v;
        pend_src_eff = take_v ? SRC_V : (take_u ? SRC_U : pend_src_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            u_ack_q    <= 1'b0;
            v_ack_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_src_q <= SRC_U;
        end else begin
            u_ack_q    <= take_u;
            v_ack_q    <= take_v;
            pend_src_q <= pend_src_eff;
            if (state_q == DONE) begin
                pend_q <= 1'b0;
            end else if (take_u || take_v) begin
                pend_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            src_q   <= SRC_U;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        src_d   = src_q;
        u_ack_c = 1'b0;
        v_ack_c = 1'b0;
        valid_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    src_d   = arb_src;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                u_ack_c = (src_q == SRC_U);
                v_ack_c = (src_q == SRC_V);
                level_d = '0;
                state_d = SWEEP;
            end
            SWEEP: begin
                valid_c = 1'b1;
                if (bus.calc_ready) begin
                    if (level_q == LAST_LEVEL) begin
                        state_d = DONE;
                    end else begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                end
            end
            DONE: begin
                done_c  = 1'b1;
`ifdef IMPLIED_COALESCE_EN
                if (pend_eff) begin
                    src_d   = pend_src_eff;
                    level_d = '0;
                    state_d = SWEEP;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef IMPLIED_COALESCE_EN
        u_ack_c = u_ack_c | (u_ack_q & bus.u_upd_req);
        v_ack_c = v_ack_c | (v_ack_q & bus.v_upd_req);
`endif
    end

    // Reset forces every output to its idle value within the same cycle.
    assign bus.u_upd_ack  = u_ack_c & ~reset;
    assign bus.v_upd_ack  = v_ack_c & ~reset;
    assign bus.calc_valid = valid_c & ~reset;
    assign bus.sweep_done = done_c & ~reset;
    assign bus.busy       = (state_q != IDLE) & ~reset;
    assign bus.calc_level = reset ? '0 : level_q;
    assign bus.calc_src   = reset ? SRC_U : src_q;

endmodule

// File: doc/implied_sweep_scheduler.md
IMPLIED_SWEEP_SCHEDULER -- requirements
Module: implied_sweep_scheduler

Interface
REQ-001 SHALL have parameter N_LEVELS, default 10: number of price levels per side swept by the implied datapath.
REQ-002 SHALL have parameter LEVEL_W, default 4: width of the level index, with 2**LEVEL_W >= N_LEVELS.
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port u_upd_req, input, width 1: book U changed; the requester holds it until it sees u_upd_ack.
REQ-006 SHALL have port u_upd_ack, output, width 1: one-cycle acceptance pulse for a book U request.
REQ-007 SHALL have ports v_upd_req (input, width 1) and v_upd_ack (output, width 1): same meaning as REQ-005/006, for book V.
REQ-008 SHALL have port calc_valid, output, width 1: calc_level is presented to the implied datapath.
REQ-009 SHALL have port calc_ready, input, width 1: the datapath accepts calc_level.
REQ-010 SHALL have port calc_level, output, width LEVEL_W: the level index currently requested.
REQ-011 SHALL have port calc_src, output, width 1: the granted source that triggered the sweep (0 = U, 1 = V).
REQ-012 SHALL have port sweep_done, output, width 1: one-cycle pulse once all levels have been accepted.
REQ-013 SHALL have port busy, output, width 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, SWEEP and DONE.
REQ-015 IDLE: if any request is high, SHALL select a winner, register calc_src and go to GRANT; otherwise SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: when both requests are high, the source not granted last wins; the first grant after reset goes to U.
REQ-017 GRANT: SHALL pulse the winner's ack for exactly one cycle, load level 0 and go to SWEEP.
REQ-018 Request-to-sweep latency: a request seen in IDLE at cycle t SHALL produce ack at t+1 and calc_valid at t+2.
REQ-019 SWEEP: calc_valid SHALL be 1, and calc_level SHALL hold stable while calc_ready is 0.
REQ-020 On calc_valid and calc_ready with level < N_LEVELS-1, SHALL increment the level by 1.
REQ-021 On calc_valid and calc_ready with level == N_LEVELS-1, SHALL go to DONE; the level SHALL never exceed N_LEVELS-1.
REQ-022 DONE: SHALL pulse sweep_done for one cycle with calc_valid 0, then go to IDLE (see REQ-029).
REQ-023 The losing or late request SHALL remain un-acked and SHALL be served through IDLE after DONE; no request is ever dropped.
REQ-024 calc_valid SHALL be 0 in IDLE, GRANT and DONE.
REQ-025 An ack SHALL never be asserted while the corresponding request is 0.

Reset
REQ-026 reset SHALL override all other inputs.
REQ-027 While reset is high: state = IDLE; calc_level = 0; calc_src = 0; round-robin pointer = U; all ack, calc_valid, sweep_done and busy outputs = 0.
REQ-028 Reset asserted mid-SWEEP SHALL abort the sweep with no sweep_done pulse; a request still held after reset SHALL be re-arbitrated.

Configuration
REQ-029 Macro IMPLIED_COALESCE_EN, when defined: a request arriving in SWEEP or DONE SHALL be acked immediately and set a pending bit; in DONE with pending set, the block SHALL pulse sweep_done, clear pending, reload level 0 and go directly to SWEEP with calc_src = the latest acked source.
REQ-030 Macro IMPLIED_COALESCE_EN, when undefined: requests SHALL be acked only in GRANT, and no pending bit SHALL exist.
REQ-031 With the macro defined, simultaneous U and V requests during a sweep SHALL both be acked in the same cycle and coalesce into a single re-sweep with calc_src = V.

Structure
REQ-032 Package implied_pkg SHALL hold the FSM state enum, the source encoding constants (SRC_U, SRC_V) and the N_LEVELS default.
REQ-033 One sub-module, rr_arbiter2 (two-requester round-robin with pointer update on grant), SHALL be instantiated; the rest SHALL be flat.

Verification
REQ-034 Single request: u_upd_req=1 at cycle 0 with calc_ready tied to 1 -> u_upd_ack at cycle 1; calc_level 0..9 on cycles 2..11; sweep_done at cycle 12; busy drops at cycle 13.
REQ-035 Contention: both requests high at reset release -> U granted first (calc_src=0); V acked on GRANT after the first DONE (calc_src=1); total 2 sweep_done pulses.
REQ-036 Backpressure: calc_ready=0 for 3 cycles while calc_level=4 -> level holds at 4; it advances to 5 only on the ready cycle; the sweep still ends at 9.
REQ-037 Reset mid-sweep: reset at calc_level=6 -> next cycle calc_valid=0, busy=0, no sweep_done; a held v_upd_req is acked 1 cycle after reset release.
REQ-038 Coalescing (IMPLIED_COALESCE_EN defined): u_upd_req and v_upd_req pulsed at calc_level=3 -> both acked next cycle; exactly one re-sweep of 10 levels follows with calc_src=1. Undefined: requests are held un-acked until IDLE.
